// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_detect_pkg;

  localparam int unsigned PAT_W_MAX    = 32;
  localparam logic [4:0]  PAT_INIT_DEF = 5'b10010;

  // Width needed to hold a fill count in the range 0..pat_w.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_nxt;

  // Next count: step by one unless already at all-ones.
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !(&cnt)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Count and saturation flag registers; sat tracks the value being stored.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= &cnt_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with run-time pattern reload, valid qualifier,
// selectable overlap behaviour and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W    = 5,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF),
  parameter bit               OVERLAP  = 1'b1,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cin,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pat,
  input  logic                       cnt_clr,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       cnt_sat,
  output logic [fill_w(PAT_W)-1:0]   fill
);

  localparam int unsigned       FILL_W    = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  sr_q;
  logic [PAT_W-1:0]  sr_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              accept;
  logic              hit;

  // Candidate shift/fill values for an accepted bit and the hit decision.
  always_comb begin
    accept   = en && !cfg_load;
    sr_nxt   = {sr_q[PAT_W-2:0], cin};
    fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit      = accept && (sr_nxt == pat_q) && (fill_inc == FILL_FULL);
  end

  // Pattern, shift register, fill level and match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PAT_INIT;
      sr_q  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (cfg_load) begin
        pat_q <= cfg_pat;
        sr_q  <= '0;
        fill  <= '0;
      end else if (en) begin
        sr_q <= sr_nxt;
        fill <= (hit && !OVERLAP) ? '0 : fill_inc;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven in lock-step and
// compared every cycle against a queue-based reference model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, en, cin, cfg_load, cnt_clr;
  logic [4:0] cfg_pat;

  logic       match_a, sat_a, match_b, sat_b, match_c, sat_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] fill_a, fill_b, fill_c;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance: 0 = overlap/8b, 1 = no-overlap/8b, 2 = overlap/2b
  bit       hist [3][$];
  bit [4:0] m_pat [3];
  int       m_cnt [3];
  bit       m_match [3];
  int       m_max [3] = '{255, 255, 3};
  bit       m_ovl [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(5), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cnt_clr(cnt_clr), .match(match_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .fill(fill_a));

  seq_detect_param #(.PAT_W(5), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cnt_clr(cnt_clr), .match(match_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .fill(fill_b));

  seq_detect_param #(.PAT_W(5), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cnt_clr(cnt_clr), .match(match_c), .match_cnt(cnt_c), .cnt_sat(sat_c), .fill(fill_c));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of inputs to the model.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit       h;
      bit [4:0] v;
      h = 1'b0;
      if (rst) begin
        hist[i].delete();
        m_pat[i]   = 5'b10010;
        m_cnt[i]   = 0;
        m_match[i] = 1'b0;
      end else begin
        if (cfg_load) begin
          hist[i].delete();
          m_pat[i] = cfg_pat;
        end else if (en) begin
          hist[i].push_back(cin);
          if (hist[i].size() > 5) void'(hist[i].pop_front());
          if (hist[i].size() == 5) begin
            v = '0;
            for (int k = 0; k < 5; k++) v = {v[3:0], hist[i][k]};
            h = (v == m_pat[i]);
          end
          if (h && !m_ovl[i]) hist[i].delete();
        end
        m_match[i] = h;
        if (cnt_clr)                     m_cnt[i] = 0;
        else if (h && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("a.match", 32'(match_a), 32'(m_match[0]));
    check("a.cnt",   32'(cnt_a),   32'(m_cnt[0]));
    check("a.sat",   32'(sat_a),   32'(m_cnt[0] == m_max[0]));
    check("a.fill",  32'(fill_a),  32'(hist[0].size()));
    check("b.match", 32'(match_b), 32'(m_match[1]));
    check("b.cnt",   32'(cnt_b),   32'(m_cnt[1]));
    check("b.sat",   32'(sat_b),   32'(m_cnt[1] == m_max[1]));
    check("b.fill",  32'(fill_b),  32'(hist[1].size()));
    check("c.match", 32'(match_c), 32'(m_match[2]));
    check("c.cnt",   32'(cnt_c),   32'(m_cnt[2]));
    check("c.sat",   32'(sat_c),   32'(m_cnt[2] == m_max[2]));
    check("c.fill",  32'(fill_c),  32'(hist[2].size()));
  endtask

  // Drive inputs away from the edge, clock once, then compare 1 time unit later.
  task automatic step(input bit e, input bit c, input bit ld = 1'b0,
                      input logic [4:0] p = 5'b0, input bit clr = 1'b0, input bit r = 1'b0);
    en = e; cin = c; cfg_load = ld; cfg_pat = p; cnt_clr = clr; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k]);
  endtask

  initial begin
    logic [31:0] s;
    en = 0; cin = 0; cfg_load = 0; cfg_pat = '0; cnt_clr = 0; rst = 1;
    #2;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Test 1: single detection of the reset pattern.
    feed(32'b10010, 5);
    check("t1.match", 32'(match_a), 32'd1);
    check("t1.cnt",   32'(cnt_a),   32'd1);
    check("t1.fill",  32'(fill_a),  32'd5);
    step(0, 0);
    check("t1.pulse_end", 32'(match_a), 32'd0);

    // Test 2: overlapping versus restarting after a hit.
    step(0, 0, 0, 0, 0, 1);
    feed(32'b10010010, 8);
    check("t2.a_cnt",  32'(cnt_a),  32'd2);
    check("t2.b_cnt",  32'(cnt_b),  32'd1);
    check("t2.b_fill", 32'(fill_b), 32'd3);

    // Test 3: idle cycles between accepted bits.
    step(0, 0, 0, 0, 0, 1);
    s = 32'b10010;
    for (int k = 4; k >= 0; k--) begin
      step(1, s[k]);
      step(0, 1'($urandom));
      step(0, 1'($urandom));
    end
    check("t3.cnt", 32'(cnt_a), 32'd1);

    // Test 4: reload discards the coincident bit; old pattern retired.
    step(0, 0, 0, 0, 0, 1);
    feed(32'b100, 3);
    step(1, 1, 1, 5'b11011);
    check("t4.fill", 32'(fill_a), 32'd0);
    feed(32'b11011, 5);
    check("t4.cnt", 32'(cnt_a), 32'd1);
    feed(32'b10010, 5);
    check("t4.old", 32'(cnt_a), 32'd1);

    // Test 5: 2-bit counter saturates, then clear collides with a hit.
    step(0, 0, 0, 0, 0, 1);
    feed(32'b10010, 5);
    for (int k = 0; k < 4; k++) feed(32'b010, 3);
    check("t5.cnt", 32'(cnt_c), 32'd3);
    check("t5.sat", 32'(sat_c), 32'd1);
    step(1, 0);
    step(1, 1);
    step(1, 0, 0, 0, 1);
    check("t5.clr_match", 32'(match_c), 32'd1);
    check("t5.clr_cnt",   32'(cnt_c),   32'd0);
    check("t5.clr_sat",   32'(sat_c),   32'd0);

    // Test 6: reset mid-stream discards history and the coincident bit.
    step(0, 0, 0, 0, 0, 1);
    feed(32'b100, 3);
    step(1, 1, 0, 0, 0, 1);
    check("t6.rst_fill", 32'(fill_a), 32'd0);
    feed(32'b10, 2);
    check("t6.fill", 32'(fill_a), 32'd2);
    check("t6.cnt",  32'(cnt_a),  32'd0);

    // Random traffic with occasional reloads, clears and resets.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 99) == 0,
           5'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
